// File: rtl/legv8_rf_pkg.sv
// Shared definitions for the LEGv8 register-file writeback path:
// register-file geometry, the writeback request shape and the arbiter priority states.
package legv8_rf_pkg;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 5;
  localparam int ZR_ADDR = 31;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    FAVOR_DFLT = 1'b0,
    FAVOR_AGED = 1'b1
  } age_state_t;

endpackage

// File: rtl/rf_wb_age_fsm.sv
// Priority/aging FSM for the writeback arbiter: counts consecutive denials of the
// default loser and hands it one conflict win once it has waited MAX_WAIT cycles.
module rf_wb_age_fsm #(
  parameter bit PRIO_LD  = 1'b1,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_alu_valid,
  input  logic i_alu_ready,
  input  logic i_ld_valid,
  input  logic i_ld_ready,
  output logic o_favor_ld
);
  import legv8_rf_pkg::*;

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  age_state_t        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  age_state_t        w_state_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_loser_valid;
  logic              w_loser_ready;

  assign w_loser_valid = PRIO_LD ? i_alu_valid : i_ld_valid;
  assign w_loser_ready = PRIO_LD ? i_alu_ready : i_ld_ready;

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FAVOR_DFLT;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Next-state: age the loser while it is held off, release after its transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = '0;
    case (r_state)
      FAVOR_DFLT: begin
        if (w_loser_valid && !w_loser_ready) begin
          if (r_wait_cnt + 1'b1 == WAIT_W'(MAX_WAIT)) begin
            w_state_nxt = FAVOR_AGED;
            w_wait_nxt  = '0;
          end else begin
            w_state_nxt = FAVOR_DFLT;
            w_wait_nxt  = r_wait_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = FAVOR_DFLT;
          w_wait_nxt  = '0;
        end
      end
      FAVOR_AGED: begin
        if (w_loser_valid && w_loser_ready) begin
          w_state_nxt = FAVOR_DFLT;
        end else begin
          w_state_nxt = FAVOR_AGED;
        end
      end
      default: begin
        w_state_nxt = FAVOR_DFLT;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // Output: which requester wins a conflict in the current state.
  always_comb begin
    o_favor_ld = PRIO_LD;
    case (r_state)
      FAVOR_DFLT: o_favor_ld = PRIO_LD;
      FAVOR_AGED: o_favor_ld = ~PRIO_LD;
      default:    o_favor_ld = PRIO_LD;
    endcase
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and load writebacks,
// registers the winning write and counts conflict cycles.
module rf_wb_arbiter #(
  parameter int DATA_W   = legv8_rf_pkg::DATA_W,
  parameter int ADDR_W   = legv8_rf_pkg::ADDR_W,
  parameter int ZR_ADDR  = legv8_rf_pkg::ZR_ADDR,
  parameter bit PRIO_LD  = 1'b1,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg_address,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  conflict_count
);
  import legv8_rf_pkg::*;

  logic              w_favor_ld;
  logic              w_alu_ready;
  logic              w_ld_ready;
  logic              w_xfer;
  logic              w_both;
  wb_req_t           w_sel;
  logic              r_reg_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_conflict_count;

  rf_wb_age_fsm #(
    .PRIO_LD  (PRIO_LD),
    .MAX_WAIT (MAX_WAIT)
  ) u_age_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_alu_valid (alu_valid),
    .i_alu_ready (w_alu_ready),
    .i_ld_valid  (ld_valid),
    .i_ld_ready  (w_ld_ready),
    .o_favor_ld  (w_favor_ld)
  );

  // Readies are held low while reset is asserted so nothing is accepted then.
  assign w_both      = alu_valid & ld_valid;
  assign w_ld_ready  = rst_n & ld_valid  & (~alu_valid | w_favor_ld);
  assign w_alu_ready = rst_n & alu_valid & (~ld_valid  | ~w_favor_ld);
  assign w_xfer      = w_ld_ready | w_alu_ready;

  // Grant mux: select the accepted request.
  always_comb begin
    w_sel = '0;
    if (w_ld_ready) begin
      w_sel = '{valid: 1'b1, addr: ld_addr, data: ld_data};
    end else if (w_alu_ready) begin
      w_sel = '{valid: 1'b1, addr: alu_addr, data: alu_data};
    end else begin
      w_sel = '0;
    end
  end

  // Output stage: one write pulse per transfer, XZR writes are suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_reg_write <= w_xfer && (w_sel.addr != ADDR_W'(ZR_ADDR));
      if (w_xfer) begin
        r_addr <= w_sel.addr;
        r_data <= w_sel.data;
      end
    end
  end

  // Saturating count of cycles with both requesters valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_count <= '0;
    end else if (w_both && (r_conflict_count != {CNT_W{1'b1}})) begin
      r_conflict_count <= r_conflict_count + 1'b1;
    end
  end

  assign alu_ready         = w_alu_ready;
  assign ld_ready          = w_ld_ready;
  assign reg_write         = r_reg_write;
  assign write_reg_address = r_addr;
  assign wr_data           = r_data;
  assign conflict_count    = r_conflict_count;

endmodule
